// File: rtl/interrupt_controller.sv
// Priority interrupt controller in front of the multi-cycle processor.
// Request lines pass through one sampling register and are edge-detected.
// Edges latch into pending bits, and a fixed-priority arbiter picks the
// winner (index 0 highest). An FSM then drives INT/NMI/INTD and tracks
// in-service state until end-of-interrupt.
module interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               eoi,
  input  logic               INA,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INT_REQ = 3'd1,
    INT_SVC = 3'd2,
    NMI_REQ = 3'd3,
    NMI_SVC = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_sync_q, irq_sync_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               nmi_sync_q, nmi_sync_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic               nested_q, nested_d;
  logic               int_q, int_d;
  logic               nmi_q, nmi_d;
  logic               intd_q, intd_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic               in_service_q, in_service_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [VEC_W-1:0]   win_idx;
  logic               win_vld;
  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] pend_clr;
  logic               nmi_clr;

  // Fixed-priority arbiter: lowest unmasked pending index wins.
  always_comb begin
    eligible = pending_q & ~mask_q;
    win_vld  = |eligible;
    win_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = VEC_W'(i);
    end
  end

  // Next-state logic: edge capture, mask load, FSM and registered outputs.
  always_comb begin
    irq_sync_d = irq;
    irq_prev_d = irq_sync_q;
    nmi_sync_d = nmi_in;
    nmi_prev_d = nmi_sync_q;
    irq_rise   = irq_sync_q & ~irq_prev_q;
    nmi_rise   = nmi_sync_q & ~nmi_prev_q;
    mask_d     = mask_wr ? mask_data : mask_q;
    state_d    = state_q;
    nested_d   = nested_q;
    vector_d   = vector_q;
    intd_d     = 1'b0;
    pend_clr   = '0;
    nmi_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (nmi_pend_q)   state_d = NMI_REQ;
        else if (win_vld) state_d = INT_REQ;
      end
      INT_REQ: begin
        // An acknowledge already issued by the processor takes precedence.
        if (INA) begin
          if (win_vld) begin
            vector_d = win_idx;
            pend_clr = NUM_IRQ'(1) << win_idx;
            intd_d   = 1'b1;
            state_d  = INT_SVC;
          end else begin
            state_d  = IDLE;
          end
        end else if (nmi_pend_q) begin
          state_d = NMI_REQ;
        end else if (!win_vld) begin
          state_d = IDLE;
        end
      end
      INT_SVC: begin
        if (eoi) begin
          state_d = IDLE;
        end else if (nmi_pend_q) begin
          nested_d = 1'b1;
          state_d  = NMI_REQ;
        end
      end
      NMI_REQ: begin
        if (INA) begin
          nmi_clr = 1'b1;
          state_d = NMI_SVC;
        end
      end
      NMI_SVC: begin
        if (eoi) begin
          state_d  = nested_q ? INT_SVC : IDLE;
          nested_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the same cycle as a clear keeps the bit set.
    pending_d    = (pending_q & ~pend_clr) | irq_rise;
    nmi_pend_d   = (nmi_pend_q & ~nmi_clr) | nmi_rise;
    int_d        = (state_d == INT_REQ);
    nmi_d        = (state_d == NMI_REQ);
    // A preempted maskable interrupt stays in service while the NMI waits.
    in_service_d = (state_d == INT_SVC) || (state_d == NMI_SVC) || nested_d;
  end

  // State register with synchronous reset; mask resets to all-masked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_sync_q   <= '0;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      nmi_sync_q   <= 1'b0;
      nmi_prev_q   <= 1'b0;
      nmi_pend_q   <= 1'b0;
      nested_q     <= 1'b0;
      int_q        <= 1'b0;
      nmi_q        <= 1'b0;
      intd_q       <= 1'b0;
      vector_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_sync_q   <= irq_sync_d;
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      nmi_sync_q   <= nmi_sync_d;
      nmi_prev_q   <= nmi_prev_d;
      nmi_pend_q   <= nmi_pend_d;
      nested_q     <= nested_d;
      int_q        <= int_d;
      nmi_q        <= nmi_d;
      intd_q       <= intd_d;
      vector_q     <= vector_d;
      in_service_q <= in_service_d;
    end
  end

  assign INT        = int_q;
  assign NMI        = nmi_q;
  assign INTD       = intd_q;
  assign vector     = vector_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Priority interrupt controller that sits directly upstream of the multi-cycle processor and drives its INT, NMI and INTD inputs. It consumes the processor's INA acknowledge. It edge-detects NUM_IRQ maskable request lines plus one non-maskable line, arbitrates them by fixed priority, and hands the processor a vector on acknowledge. It tracks in-service state until the interrupt handler signals end-of-interrupt (EOI).

Parameters:
NUM_IRQ, 8, number of maskable request lines. Index 0 has the highest priority.
VEC_W, 3, width of the vector output. Must satisfy 2**VEC_W >= NUM_IRQ.

Ports:
clk  input  1  single system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
irq  input  NUM_IRQ  maskable request lines, rising-edge triggered
nmi_in  input  1  non-maskable request, rising-edge triggered
mask_wr  input  1  one-cycle strobe that loads mask_data into the mask register
mask_data  input  NUM_IRQ  new mask value; bit=1 masks that line
eoi  input  1  one-cycle end-of-interrupt pulse from the handler
INA  input  1  interrupt acknowledge from the processor
INT  output  1  maskable interrupt request to the processor
NMI  output  1  non-maskable request to the processor
INTD  output  1  one-cycle strobe: vector is valid for a maskable acknowledge
vector  output  VEC_W  index of the acknowledged maskable line; held until the next maskable acknowledge
pending  output  NUM_IRQ  latched pending bits; does not include the NMI pending flag
in_service  output  1  high while any interrupt is in service

Behaviour:
- Reset: all registered state cleared, except the mask register.
  - INT=0, NMI=0, INTD=0, vector=0, pending=0, in_service=0.
  - Mask register = all ones.
  - nmi_pend=0, nested=0, state=IDLE.
  - irq_prev=0 and nmi_prev=0, so a line held high across reset release registers one edge.
  - Reset mid-operation aborts everything; any pending or acknowledged interrupt is lost.
- Edge detection:
  - pending[i] is set on the edge after irq[i] is sampled high with irq_prev[i]=0. Same for nmi_pend.
  - An edge on an already-set bit is absorbed; there is no counting.
  - Set and clear of the same bit in one cycle: set wins.
- Masking: the mask affects only the request and arbitration logic. Masked lines still latch pending.
- eligible = pending & ~mask. Winner = lowest index of eligible.
- FSM states: IDLE, INT_REQ, INT_SVC, NMI_REQ, NMI_SVC.
- IDLE:
  - nmi_pend=1 -> NMI_REQ (NMI wins over INT).
  - Else eligible!=0 -> INT_REQ.
  - Outputs are registered, so INT/NMI rise on the edge that enters the state. Latency from irq sampled high to INT high is 2 clocks.
- INT_REQ:
  - INT=1 is held until INA is sampled high.
  - If nmi_pend sets first -> drop INT, go to NMI_REQ.
  - If eligible becomes 0 (mask written) before INA -> drop INT, go to IDLE.
  - On INA with eligible!=0:
    - Winner is re-evaluated on that cycle.
    - vector<=winner, pending[winner] cleared, INT<=0.
    - INTD=1 for exactly one cycle, on the edge of the next cycle.
    - Go to INT_SVC.
  - On INA with eligible=0: go to IDLE, no INTD.
- INT_SVC:
  - in_service=1.
  - eoi -> IDLE.
  - nmi_pend -> set nested=1, go to NMI_REQ.
  - New maskable edges only latch pending; there is no maskable nesting.
- NMI_REQ:
  - NMI=1 until INA is sampled high.
  - On INA: nmi_pend cleared, NMI<=0, INTD not pulsed, vector unchanged, go to NMI_SVC.
- NMI_SVC:
  - in_service=1.
  - eoi -> INT_SVC if nested=1 (clear nested), else IDLE.
  - A new nmi_in edge latches nmi_pend and is serviced after the EOI.
- eoi in IDLE, INT_REQ or NMI_REQ is ignored.
- INA outside INT_REQ/NMI_REQ is ignored.
- mask_wr takes effect on the next cycle's eligible evaluation.
- eoi and a new edge in the same cycle: both take effect.
- INT and NMI are never high together.

Test Plan:
- Single request: reset; mask_data=8'h00, mask_wr. Pulse irq[5].
  -> INT high 2 cycles later. Raise INA -> next cycle INT=0, INTD=1 for 1 cycle, vector=5, pending[5]=0, in_service=1. eoi -> in_service=0.
- Priority: irq[6] and irq[2] rise together, mask 8'h00.
  -> first INA gives vector=2, pending=8'h40. After eoi, INT re-asserts; second INA gives vector=6.
- Masking: mask=8'hFF, pulse irq[3].
  -> pending[3]=1, INT stays 0. Write mask=8'hF7 -> INT high 1 cycle later. Rewrite 8'hFF before INA -> INT drops, FSM returns to IDLE, pending[3] still 1.
- NMI preemption: service irq[1] to INT_SVC, then pulse nmi_in.
  -> NMI=1, INT=0. INA -> INTD stays 0, vector stays 1. eoi -> back to INT_SVC, in_service=1. Second eoi -> in_service=0.
- Simultaneous: nmi_in and irq[0] rise in the same cycle.
  -> NMI asserted first, INT=0. After NMI acknowledge and eoi, INT asserts for irq[0], pending[0] retained throughout.
- Reset mid-operation: assert reset while in INT_REQ with INT=1 and irq[4] held high.
  -> next cycle all outputs 0, mask=8'hFF. After reset release, pending[4]=1 (edge from irq_prev=0).
